rv32i_wb_stage: RTL
===================

# rv32i_wb_stage

Writeback stage for the RV32I core; sits directly upstream of the register file and drives its `rd_addr`/`rd_data`/`rd_we` write port. Accepts completed results from execute: ALU results retire immediately, loads wait for the data-memory response. Load data is lane-extracted and sign/zero-extended before writeback. A pending-load indication is exported so decode can stall on load-use hazards.

## Interface
- `XLEN`, 32, data width (from `rv32i_pkg`)
- `REG_ADDR_WIDTH`, 5, register index width (from `rv32i_pkg`)
- `clk`  in  1  core clock
- `rst_n`  in  1  asynchronous active-low reset
- `ex_valid`  in  1  execute presents a result
- `ex_ready`  out  1  stage accepts this cycle
- `ex_rd_addr`  in  REG_ADDR_WIDTH  destination register
- `ex_result`  in  XLEN  ALU result (ignored for loads)
- `ex_is_load`  in  1  instruction is a load
- `ex_funct3`  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
- `ex_addr_lo`  in  2  load address bits [1:0]
- `mem_rvalid`  in  1  load response valid
- `mem_rdata`  in  XLEN  load response word (naturally aligned)
- `mem_err`  in  1  bus error with response
- `rd_addr`  out  REG_ADDR_WIDTH  regfile write address
- `rd_data`  out  XLEN  regfile write data
- `rd_we`  out  1  regfile write enable
- `load_pending`  out  1  load outstanding
- `pend_rd_addr`  out  REG_ADDR_WIDTH  destination of outstanding load
- `load_fault`  out  1  one-cycle pulse: load error or illegal funct3
- `fwd_valid`  out  1  bypass valid (see Configuration)
- `fwd_addr`  out  REG_ADDR_WIDTH  bypass register
- `fwd_data`  out  XLEN  bypass data

## Operation
- States: IDLE, LOAD_WAIT.
- IDLE: `ex_ready`=1. On `ex_valid` and `!ex_is_load`: register result; next cycle `rd_we`=1, `rd_addr`=`ex_rd_addr`, `rd_data`=`ex_result`. Stay in IDLE.
- IDLE, `ex_valid` and `ex_is_load` with legal funct3: capture rd/funct3/addr_lo, go to LOAD_WAIT. Illegal funct3 (011, 110, 111): no state change, no write, `load_fault` pulses next cycle.
- LOAD_WAIT: `ex_ready`=0, `load_pending`=1, `pend_rd_addr`=captured rd. On `mem_rvalid`: if `mem_err`, no write, `load_fault` pulses next cycle; else write extracted data next cycle. Return to IDLE in both cases.
- Extraction: byte lane = `addr_lo`, half lane = `addr_lo[1]` (`addr_lo[0]` ignored for halves; LW ignores `addr_lo`). LB/LH sign-extend, LBU/LHU zero-extend.
- `rd_addr`=0 destination: `rd_we` held 0 (no write to x0). Faults and handshakes behave normally.
- `mem_rvalid` in IDLE is ignored.
- `rd_we` is a single-cycle pulse per retired instruction. `rd_addr`/`rd_data` hold their last value when `rd_we`=0.

## Timing
- Reset values: state IDLE; `rd_we`, `rd_addr`, `rd_data`, `load_pending`, `pend_rd_addr`, `load_fault`, `fwd_*` all 0. `ex_ready`=1 (combinational from state).
- ALU result: write 1 cycle after acceptance. Back-to-back ALU results retire at 1 per cycle.
- Load: write 1 cycle after `mem_rvalid`. `load_pending` rises the cycle after acceptance and falls the cycle after `mem_rvalid`.
- `mem_rvalid` may arrive the cycle after acceptance (minimum load latency 2 cycles accept-to-write).
- A new instruction is accepted in the same cycle that the write of the previous load is presented.
- Reset mid-load: pending load discarded, no write; a later `mem_rvalid` is ignored.

## Configuration
- `RV32I_WB_FWD_EN` defined: `fwd_valid`/`fwd_addr`/`fwd_data` mirror `rd_we`/`rd_addr`/`rd_data` exactly in the same cycle. Decode uses them to bypass the regfile's read-during-write old value; `fwd_valid`=0 whenever `rd_addr`=0.
- Undefined: `fwd_*` tied to 0. Ports remain present, so the interface is unchanged.

## Test plan
- ALU: `ex_valid`, rd=5, result 0xDEADBEEF -> next cycle `rd_we`=1, rd 5, data 0xDEADBEEF; 3 back-to-back -> 3 consecutive writes.
- LB, addr_lo=3, response 0x80FF_0000 -> write 0xFFFFFF80; LBU same -> 0x00000080; LH, addr_lo=2 -> 0xFFFF80FF; LHU -> 0x000080FF.
- LW, rd=7, response delayed 4 cycles -> `ex_ready`=0 and `load_pending`=1 with `pend_rd_addr`=7 throughout; write 1 cycle after `mem_rvalid`.
- Load with `mem_err`=1 -> no `rd_we`, one-cycle `load_fault`; funct3=011 -> `load_fault`, state stays IDLE.
- rd=0 ALU and load -> `rd_we` never asserted; `fwd_valid`=0 when the macro is defined.
- Reset asserted during LOAD_WAIT, then `mem_rvalid` -> all outputs 0, no write; with `RV32I_WB_FWD_EN`, `fwd_*` equals `rd_*` every cycle of the ALU test.

Source files
------------

// File: rtl/rv32i_wb_stage.sv
// RV32I writeback stage: retires ALU results, waits for and lane-extracts load data.
// Define RV32I_WB_FWD_EN to drive the fwd_* bypass port; otherwise it is tied to zero.
module rv32i_wb_stage #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    output logic                      ex_ready,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic [XLEN-1:0]           ex_result,
    input  logic                      ex_is_load,
    input  logic [2:0]                ex_funct3,
    input  logic [1:0]                ex_addr_lo,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata,
    input  logic                      mem_err,
    output logic [REG_ADDR_WIDTH-1:0] rd_addr,
    output logic [XLEN-1:0]           rd_data,
    output logic                      rd_we,
    output logic                      load_pending,
    output logic [REG_ADDR_WIDTH-1:0] pend_rd_addr,
    output logic                      load_fault,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic [XLEN-1:0]           fwd_data
);

    typedef enum logic [0:0] {StIdle, StLoadWait} state_e;

    state_e                    state_q, state_d;
    logic                      rd_we_q, rd_we_d;
    logic [REG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [XLEN-1:0]           rd_data_q, rd_data_d;
    logic                      fault_q, fault_d;
    logic [REG_ADDR_WIDTH-1:0] pend_rd_q, pend_rd_d;
    logic [2:0]                funct3_q, funct3_d;
    logic [1:0]                addr_lo_q, addr_lo_d;
    logic                      funct3_legal;

    function automatic logic [XLEN-1:0] extract(input logic [2:0]      f3,
                                                input logic [1:0]      lo,
                                                input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  extract = {{(XLEN-8){b[7]}}, b};
            3'b001:  extract = {{(XLEN-16){h[15]}}, h};
            3'b100:  extract = {{(XLEN-8){1'b0}}, b};
            3'b101:  extract = {{(XLEN-16){1'b0}}, h};
            default: extract = w;
        endcase
    endfunction

    always_comb begin
        case (ex_funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
            default:                                funct3_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        rd_we_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        fault_d   = 1'b0;
        pend_rd_d = pend_rd_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        unique case (state_q)
            StIdle: begin
                if (ex_valid) begin
                    if (!ex_is_load) begin
                        // x0 writes are dropped and leave rd_addr/rd_data untouched
                        if (ex_rd_addr != '0) begin
                            rd_we_d   = 1'b1;
                            rd_addr_d = ex_rd_addr;
                            rd_data_d = ex_result;
                        end
                    end else if (funct3_legal) begin
                        pend_rd_d = ex_rd_addr;
                        funct3_d  = ex_funct3;
                        addr_lo_d = ex_addr_lo;
                        state_d   = StLoadWait;
                    end else begin
                        fault_d = 1'b1;
                    end
                end
            end
            StLoadWait: begin
                if (mem_rvalid) begin
                    state_d = StIdle;
                    if (mem_err) begin
                        fault_d = 1'b1;
                    end else if (pend_rd_q != '0) begin
                        rd_we_d   = 1'b1;
                        rd_addr_d = pend_rd_q;
                        rd_data_d = extract(funct3_q, addr_lo_q, mem_rdata);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_we_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            fault_q   <= 1'b0;
            pend_rd_q <= '0;
            funct3_q  <= 3'b000;
            addr_lo_q <= 2'b00;
        end else begin
            state_q   <= state_d;
            rd_we_q   <= rd_we_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            fault_q   <= fault_d;
            pend_rd_q <= pend_rd_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
        end
    end

    assign ex_ready     = (state_q == StIdle);
    assign load_pending = (state_q == StLoadWait);
    assign pend_rd_addr = load_pending ? pend_rd_q : '0;
    assign rd_we        = rd_we_q;
    assign rd_addr      = rd_addr_q;
    assign rd_data      = rd_data_q;
    assign load_fault   = fault_q;

`ifdef RV32I_WB_FWD_EN
    assign fwd_valid = rd_we_q && (rd_addr_q != '0);
    assign fwd_addr  = rd_addr_q;
    assign fwd_data  = rd_data_q;
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

endmodule
